// File: rtl/divider_pkg.sv
// rtl/divider_pkg.sv - shared state encoding and width helper for the iterative divider
package divider_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Counter width able to hold the value n (iteration count loaded at start).
  function automatic int count_width(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/divider_if.sv
// rtl/divider_if.sv - start/operand and result bundle between controller and divider
interface divider_if #(
  parameter int N = 4
);
  logic         i_start;
  logic [N-1:0] i_dividend;
  logic [N-1:0] i_divisor;
  logic         o_finished;
  logic [N-1:0] o_quotient;
  logic [N-1:0] o_remainder;
  logic         o_divide_by_zero;

  modport master (
    output i_start, i_dividend, i_divisor,
    input  o_finished, o_quotient, o_remainder, o_divide_by_zero
  );

  modport slave (
    input  i_start, i_dividend, i_divisor,
    output o_finished, o_quotient, o_remainder, o_divide_by_zero
  );
endinterface

// File: rtl/divider_step.sv
// rtl/divider_step.sv - one combinational restoring-division iteration
module divider_step #(
  parameter int N = 4
) (
  input  logic [N-1:0] r_in,
  input  logic [N-1:0] q_in,
  input  logic [N-1:0] divisor,
  output logic [N-1:0] r_out,
  output logic [N-1:0] q_out
);

  logic [N:0]   r_shift;
  logic [N-1:0] r_diff;
  logic         below;

  // Shift {R,Q} left, trial-subtract the divisor and restore when it does not fit.
  // The shifted remainder needs N+1 bits for the compare, but a successful
  // subtraction always lands below the divisor, so N bits hold the difference.
  always_comb begin
    r_shift = {r_in, q_in[N-1]};
    below   = (r_shift < {1'b0, divisor});
    r_diff  = r_shift[N-1:0] - divisor;
    r_out   = below ? r_shift[N-1:0] : r_diff;
    q_out   = {q_in[N-2:0], ~below};
  end

endmodule

// File: rtl/divider.sv
// rtl/divider.sv - multi-cycle restoring divider top (optional signed mode: DIVIDER_SIGNED_EN)
module divider
  import divider_pkg::*;
#(
  parameter int N = 4
) (
  input  logic     i_clock,
  input  logic     i_reset,
  divider_if.slave bus
);

  localparam int             CW    = count_width(N);
  localparam logic [CW-1:0]  CNT_N = CW'(N);
  localparam logic [CW-1:0]  CNT_1 = CW'(1);

  state_t        state_q, state_d;
  logic [CW-1:0] count_q, count_d;
  logic [N-1:0]  r_q, r_d;
  logic [N-1:0]  q_q, q_d;
  logic [N-1:0]  divisor_q, divisor_d;
  logic [N-1:0]  dividend_q, dividend_d;
  logic          zero_q, zero_d;
  logic          finished_q, finished_d;
  logic          dbz_q, dbz_d;
  logic [N-1:0]  quotient_q, quotient_d;
  logic [N-1:0]  remainder_q, remainder_d;
  logic [N-1:0]  step_r, step_q;
  logic [N-1:0]  dividend_mag, divisor_mag;
  logic [N-1:0]  quotient_fix, remainder_fix;
`ifdef DIVIDER_SIGNED_EN
  logic          neg_quot_q, neg_quot_d;
  logic          neg_rem_q, neg_rem_d;
`endif

  divider_step #(.N(N)) u_step (
    .r_in    (r_q),
    .q_in    (q_q),
    .divisor (divisor_q),
    .r_out   (step_r),
    .q_out   (step_q)
  );

  // Operand magnitudes fed to the unsigned core and sign fix-up of the final step.
  always_comb begin
`ifdef DIVIDER_SIGNED_EN
    dividend_mag  = bus.i_dividend[N-1] ? -bus.i_dividend : bus.i_dividend;
    divisor_mag   = bus.i_divisor[N-1]  ? -bus.i_divisor  : bus.i_divisor;
    quotient_fix  = neg_quot_q ? -step_q : step_q;
    remainder_fix = neg_rem_q  ? -step_r : step_r;
`else
    dividend_mag  = bus.i_dividend;
    divisor_mag   = bus.i_divisor;
    quotient_fix  = step_q;
    remainder_fix = step_r;
`endif
  end

  // State and datapath registers; reset aborts any operation in flight.
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      state_q     <= IDLE;
      count_q     <= '0;
      r_q         <= '0;
      q_q         <= '0;
      divisor_q   <= '0;
      dividend_q  <= '0;
      zero_q      <= 1'b0;
      finished_q  <= 1'b0;
      dbz_q       <= 1'b0;
      quotient_q  <= '0;
      remainder_q <= '0;
`ifdef DIVIDER_SIGNED_EN
      neg_quot_q  <= 1'b0;
      neg_rem_q   <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      r_q         <= r_d;
      q_q         <= q_d;
      divisor_q   <= divisor_d;
      dividend_q  <= dividend_d;
      zero_q      <= zero_d;
      finished_q  <= finished_d;
      dbz_q       <= dbz_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
`ifdef DIVIDER_SIGNED_EN
      neg_quot_q  <= neg_quot_d;
      neg_rem_q   <= neg_rem_d;
`endif
    end
  end

  // Next state: start is honoured only outside RUN; RUN ends when the last count is consumed.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE, DONE: if (bus.i_start) state_d = RUN;
      RUN:        if (count_q == CNT_1) state_d = DONE;
      default:    state_d = IDLE;
    endcase
  end

  // Datapath and result registers; a zero divisor runs a single dummy cycle so it reaches DONE after one clock.
  always_comb begin
    count_d     = count_q;
    r_d         = r_q;
    q_d         = q_q;
    divisor_d   = divisor_q;
    dividend_d  = dividend_q;
    zero_d      = zero_q;
    finished_d  = finished_q;
    dbz_d       = dbz_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
`ifdef DIVIDER_SIGNED_EN
    neg_quot_d  = neg_quot_q;
    neg_rem_d   = neg_rem_q;
`endif
    case (state_q)
      IDLE, DONE: begin
        if (bus.i_start) begin
          finished_d = 1'b0;
          dbz_d      = 1'b0;
          dividend_d = bus.i_dividend;
          divisor_d  = divisor_mag;
          r_d        = '0;
          q_d        = dividend_mag;
          zero_d     = (bus.i_divisor == '0);
          count_d    = (bus.i_divisor == '0) ? CNT_1 : CNT_N;
`ifdef DIVIDER_SIGNED_EN
          neg_quot_d = bus.i_dividend[N-1] ^ bus.i_divisor[N-1];
          neg_rem_d  = bus.i_dividend[N-1];
`endif
        end
      end
      RUN: begin
        r_d     = step_r;
        q_d     = step_q;
        count_d = count_q - CNT_1;
        if (count_q == CNT_1) begin
          finished_d = 1'b1;
          if (zero_q) begin
            dbz_d       = 1'b1;
            quotient_d  = '1;
            remainder_d = dividend_q;
          end else begin
            quotient_d  = quotient_fix;
            remainder_d = remainder_fix;
          end
        end
      end
      default: ;
    endcase
  end

  assign bus.o_finished       = finished_q;
  assign bus.o_divide_by_zero = dbz_q;
  assign bus.o_quotient       = quotient_q;
  assign bus.o_remainder      = remainder_q;

endmodule

// File: tb/tb_divider.sv
// tb/tb_divider.sv - scoreboard bench for divider (expectations follow DIVIDER_SIGNED_EN)
module tb_divider;

  localparam int N = 4;
`ifdef DIVIDER_SIGNED_EN
  localparam bit SIGNED_MODE = 1'b1;
`else
  localparam bit SIGNED_MODE = 1'b0;
`endif

  typedef struct {
    logic [N-1:0] q;
    logic [N-1:0] r;
    logic         dbz;
    int           fin_cycle;
    string        name;
  } exp_t;

  exp_t sb[$];
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic fin_prev = 1'b0;
  int   cycle = 0;
  int   n_checks = 0;
  int   n_fail = 0;

  divider_if #(.N(N)) bus();

  divider #(.N(N)) dut (
    .i_clock (clk),
    .i_reset (rst_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cycle <= cycle + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference arithmetic used for the exhaustive sweep.
  function automatic void model(input logic [N-1:0] a, input logic [N-1:0] b,
                                output logic [N-1:0] q, output logic [N-1:0] r, output logic d);
`ifdef DIVIDER_SIGNED_EN
    int sa;
    int sd;
`endif
    if (b == '0) begin
      q = '1;
      r = a;
      d = 1'b1;
    end else begin
`ifdef DIVIDER_SIGNED_EN
      sa = $signed(a);
      sd = $signed(b);
      q  = N'(sa / sd);
      r  = N'(sa % sd);
`else
      q  = a / b;
      r  = a % b;
`endif
      d  = 1'b0;
    end
  endfunction

  // Monitor: every rising o_finished retires one scoreboard entry.
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      fin_prev = 1'b0;
    end else begin
      if (bus.o_finished && !fin_prev) begin
        if (sb.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_finish: got finished=1 expected no pending operation");
        end else begin
          e = sb.pop_front();
          check({e.name, "_quotient"},  bus.o_quotient, e.q);
          check({e.name, "_remainder"}, bus.o_remainder, e.r);
          check({e.name, "_dbz"},       bus.o_divide_by_zero, e.dbz);
          check({e.name, "_latency"},   cycle, e.fin_cycle);
        end
      end
      fin_prev = bus.o_finished;
    end
  end

  // Called at a falling edge; start is accepted at the following rising edge.
  task automatic issue(input string name, input logic [N-1:0] a, input logic [N-1:0] b,
                       input logic [N-1:0] eq, input logic [N-1:0] er, input logic edbz);
    exp_t e;
    bus.i_start    = 1'b1;
    bus.i_dividend = a;
    bus.i_divisor  = b;
    e.q         = eq;
    e.r         = er;
    e.dbz       = edbz;
    e.fin_cycle = cycle + 1 + ((b == '0) ? 1 : N);
    e.name      = name;
    sb.push_back(e);
    @(posedge clk);
    #1;
    bus.i_start    = 1'b0;
    bus.i_dividend = N'($urandom);
    bus.i_divisor  = N'($urandom);
  endtask

  task automatic wait_done(input string name);
    for (int i = 0; i < 3 * N; i++) begin
      @(negedge clk);
      if (bus.o_finished) return;
    end
    n_checks++;
    n_fail++;
    $display("FAIL %s_timeout: got finished=0 expected finished=1 within %0d cycles", name, 3 * N);
  endtask

  initial begin
    logic [N-1:0] mq, mr;
    logic         md;
    bus.i_start    = 1'b0;
    bus.i_dividend = '0;
    bus.i_divisor  = '0;
    repeat (3) @(negedge clk);
    check("reset_finished",  bus.o_finished, 0);
    check("reset_quotient",  bus.o_quotient, 0);
    check("reset_remainder", bus.o_remainder, 0);
    check("reset_dbz",       bus.o_divide_by_zero, 0);
    rst_n = 1'b1;
    @(negedge clk);

    issue("d13_3", 4'd13, 4'd3, SIGNED_MODE ? 4'd15 : 4'd4, SIGNED_MODE ? 4'd0 : 4'd1, 1'b0);
    wait_done("d13_3");
    issue("d7_0", 4'd7, 4'd0, 4'd15, 4'd7, 1'b1);
    check("restart_in_done_clears_finished", bus.o_finished, 0);
    wait_done("d7_0");
    issue("d2_9", 4'd2, 4'd9, 4'd0, 4'd2, 1'b0);
    wait_done("d2_9");
    issue("d15_1", 4'd15, 4'd1, 4'd15, 4'd0, 1'b0);
    wait_done("d15_1");

    issue("ignored_start", 4'd13, 4'd3, SIGNED_MODE ? 4'd15 : 4'd4, SIGNED_MODE ? 4'd0 : 4'd1, 1'b0);
    @(negedge clk);
    @(negedge clk);
    bus.i_start    = 1'b1;
    bus.i_dividend = 4'd15;
    bus.i_divisor  = 4'd1;
    @(posedge clk);
    #1;
    bus.i_start = 1'b0;
    wait_done("ignored_start");

    issue("aborted", 4'd9, 4'd2, SIGNED_MODE ? 4'd13 : 4'd4, SIGNED_MODE ? 4'd15 : 4'd1, 1'b0);
    @(posedge clk);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("midrun_reset_finished",  bus.o_finished, 0);
    check("midrun_reset_quotient",  bus.o_quotient, 0);
    check("midrun_reset_remainder", bus.o_remainder, 0);
    check("midrun_reset_dbz",       bus.o_divide_by_zero, 0);
    sb.delete();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_reset_idle_finished", bus.o_finished, 0);
    issue("d12_4", 4'd12, 4'd4, SIGNED_MODE ? 4'd15 : 4'd3, 4'd0, 1'b0);
    wait_done("d12_4");

`ifdef DIVIDER_SIGNED_EN
    issue("sm7_2", 4'd9, 4'd2, 4'd13, 4'd15, 1'b0);
    wait_done("sm7_2");
    issue("sm8_m1", 4'd8, 4'd15, 4'd8, 4'd0, 1'b0);
    wait_done("sm8_m1");
`endif

    for (int a = 0; a < (1 << N); a++) begin
      for (int b = 0; b < (1 << N); b++) begin
        model(N'(a), N'(b), mq, mr, md);
        issue($sformatf("sweep_%0d_%0d", a, b), N'(a), N'(b), mq, mr, md);
        wait_done("sweep");
      end
    end

    repeat (2) @(negedge clk);
    check("scoreboard_drained", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
